alu_muldiv: RTL
===============

Name: alu_muldiv

Overview:
- Parametrised multi-cycle successor to the single-cycle integer ALU. Executes the RV32M multiply/divide group (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Iterative engine, one bit per cycle. Valid/ready handshake on both input and output sides.
- Sits beside the combinational ALU in the execute stage. The core stalls on in_ready/out_valid.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and ≥4.
- OPCODE_LENGTH, 3, Operation width; carries funct3 of the M-extension instruction.

Ports:
- clk  input  1  single clock. All logic is on the rising edge.
- reset  input  1  synchronous, active-high reset. Sampled on the rising edge of clk.
- flush  input  1  synchronous abort of any in-flight or held operation.
- in_valid  input  1  SrcA/SrcB/Operation valid.
- in_ready  output  1  block can accept an operation this cycle.
- SrcA  input  DATA_WIDTH  rs1 operand.
- SrcB  input  DATA_WIDTH  rs2 operand.
- Operation  input  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- out_valid  output  1  ALUResult valid.
- out_ready  input  1  consumer takes the result.
- ALUResult  output  DATA_WIDTH  result. Held stable while out_valid=1 and out_ready=0.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset: state=IDLE, out_valid=0, ALUResult=0, busy=0, in_ready=1. reset has priority over flush and all handshakes.
- Handshake rules:
  - accept when in_valid & in_ready.
  - retire when out_valid & out_ready.
  - in_ready = (state==IDLE) | (state==DONE & out_ready), which allows back-to-back operation.
- FSM states: IDLE, CALC, DONE.
- IDLE to CALC on accept. Operands are latched into internal registers; inputs may change afterwards.
- IDLE to DONE directly on accept of a special division case (below). Result is available on the next cycle.
- CALC: iteration counter runs DATA_WIDTH-1 down to 0, one bit per cycle. CALC to DONE after exactly DATA_WIDTH cycles.
- DONE: out_valid=1.
  - DONE to IDLE on retire with no new accept.
  - DONE to CALC/DONE on retire combined with a simultaneous accept.
- Latency: accept in cycle 0 gives out_valid=1 in cycle DATA_WIDTH+1 (33 for W=32). Special cases give out_valid in cycle 1.
- Multiply:
  - Operands converted to magnitudes: SrcA signed for MUL/MULH/MULHSU; SrcB signed for MUL/MULH only.
  - Shift-add over a 2*DATA_WIDTH product register. Negate if the operand signs differ.
  - MUL returns product[W-1:0]. MULH/MULHSU/MULHU return product[2W-1:W].
  - MUL low half is identical for signed and unsigned.
- Divide:
  - Restoring division on magnitudes. DIV/REM are signed, DIVU/REMU unsigned.
  - Quotient sign = sign(A) xor sign(B). Remainder takes the sign of the dividend.
  - Invariant: A == Q*B + R, with |R| < |B|.
- Special cases, resolved in IDLE with no CALC:
  - B==0: DIV/DIVU give all-ones; REM/REMU give SrcA.
  - Signed overflow, A==MIN (1<<(W-1)) and B==all-ones, for DIV/REM only: DIV gives MIN; REM gives 0.
- Arithmetic wraps modulo 2^W; no exception outputs.
- flush (when reset=0):
  - next state IDLE, out_valid=0. Any in-flight result is discarded and never presented.
  - in_ready is still computed from the current state, but an accept in the flush cycle is dropped.
- Reset mid-CALC: same outcome as flush, plus ALUResult=0.
- ALUResult is only updated on entry to DONE. It holds its last value in IDLE.
- out_ready while not out_valid has no effect.

Test Plan:
- MUL, W=32, A=7, B=-3 (0xFFFFFFFD) -> out_valid in cycle 33 after accept, ALUResult=0xFFFFFFEB. Hold out_ready=0 for 5 cycles -> value stable, in_ready=0.
- MULH/MULHSU/MULHU with A=B=0xFFFFFFFF -> 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively.
- DIV A=-7, B=2 -> 0xFFFFFFFD (-3). REM -> 0xFFFFFFFF (-1). DIVU A=100, B=7 -> 14. REMU -> 2.
- DIVU A=5, B=0 -> 0xFFFFFFFF in cycle 1. REM A=5, B=0 -> 5. DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000. REM same operands -> 0. Special cases never enter CALC.
- Back-to-back: hold in_valid=1 with out_ready=1 -> second op accepted in the retire cycle of the first, with no IDLE bubble.
- Abort paths:
  - flush in CALC cycle 10 -> IDLE next cycle, out_valid never rises, the next op gives the correct result.
  - reset in CALC -> ALUResult=0, in_ready=1.
- Random: 10k random operands per op against a reference model, including W=8 and W=16 builds.

Source files
------------

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Purpose  : Iterative RV32M multiply/divide unit. It retires one bit per
//            cycle through a shared 2*DATA_WIDTH shift register. Shift-add
//            is used for MUL*, and restoring division for DIV*/REM*.
//            Divide-by-zero and signed overflow are resolved on accept, with
//            no iteration.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (priority over everything)
//   flush      in   synchronous abort of in-flight / held operation
//   in_valid   in   SrcA/SrcB/Operation valid
//   in_ready   out  operation can be accepted this cycle
//   SrcA       in   rs1 operand
//   SrcB       in   rs2 operand
//   Operation  in   funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   out_valid  out  ALUResult valid
//   out_ready  in   consumer takes the result
//   ALUResult  out  result, held while out_valid & !out_ready
//   busy       out  state is not IDLE
// ============================================================================
module alu_muldiv #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     busy
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [2:0] c_op_mul    = 3'b000;
  localparam logic [2:0] c_op_mulh   = 3'b001;
  localparam logic [2:0] c_op_mulhsu = 3'b010;
  localparam logic [2:0] c_op_mulhu  = 3'b011;
  localparam logic [2:0] c_op_div    = 3'b100;
  localparam logic [2:0] c_op_divu   = 3'b101;
  localparam logic [2:0] c_op_rem    = 3'b110;
  localparam logic [2:0] c_op_remu   = 3'b111;

  localparam logic [W-1:0] c_all_ones = {W{1'b1}};
  localparam logic [W-1:0] c_min      = {1'b1, {(W-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide  : {partial remainder, dividend bits shifting into quotient}.
  logic [2*W-1:0]   prod_q,   prod_d;
  // Multiply: multiplicand magnitude. Divide: divisor magnitude.
  logic [W-1:0]     opnd_q,   opnd_d;
  logic [2:0]       op_q,     op_d;
  logic             neg_q,    neg_d;    // product / quotient must be negated
  logic             rneg_q,   rneg_d;   // remainder must be negated (dividend sign)
  logic [W-1:0]     result_q, result_d;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_accept;

  assign in_ready  = (state_q == c_st_idle) | ((state_q == c_st_done) & out_ready);
  assign out_valid = (state_q == c_st_done);
  assign busy      = (state_q != c_st_idle);
  assign ALUResult = result_q;
  assign w_accept  = in_valid & in_ready;

  // --------------------------------------------------------------------------
  // Operand decode on the incoming operation
  // --------------------------------------------------------------------------
  logic [2:0]   w_op;
  logic         w_is_div;
  logic         w_a_signed, w_b_signed;
  logic         w_sa, w_sb;
  logic [W-1:0] w_a_mag, w_b_mag;
  logic         w_b_zero, w_ovf, w_special;
  logic [W-1:0] w_special_res;

  assign w_op     = Operation[2:0];
  assign w_is_div = w_op[2];

  // MUL/MULH/MULHSU treat A as signed, and MUL/MULH treat B as signed.
  // DIV/REM treat both as signed.
  assign w_a_signed = w_is_div ? ~w_op[0] : (w_op[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~w_op[0] : ~w_op[1];

  assign w_sa    = w_a_signed & SrcA[W-1];
  assign w_sb    = w_b_signed & SrcB[W-1];
  assign w_a_mag = w_sa ? (-SrcA) : SrcA;
  assign w_b_mag = w_sb ? (-SrcB) : SrcB;

  assign w_b_zero  = w_is_div & (SrcB == '0);
  assign w_ovf     = w_is_div & ~w_op[0] & (SrcA == c_min) & (SrcB == c_all_ones);
  assign w_special = w_b_zero | w_ovf;

  // op[1] separates the REM pair from the DIV pair.
  always_comb begin
    w_special_res = '0;
    if (w_b_zero) begin
      w_special_res = w_op[1] ? SrcA : c_all_ones;
    end else begin
      w_special_res = w_op[1] ? '0 : c_min;
    end
  end

  // --------------------------------------------------------------------------
  // One iteration step
  // --------------------------------------------------------------------------
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;
  logic [W:0]     w_div_shift;
  logic [W:0]     w_div_diff;
  logic [2*W-1:0] w_div_next;

  // Shift-add: add the multiplicand when the current multiplier LSB is set,
  // then shift the whole register right. The carry lands in the top bit.
  assign w_mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign w_mul_next = {w_mul_sum, prod_q[W-1:1]};

  // Restoring divide: bring in the next dividend bit, and try to subtract.
  // A borrow (diff[W]) means the subtraction is undone, and the quotient
  // bit is set to 0.
  assign w_div_shift = {prod_q[2*W-1:W], prod_q[W-1]};
  assign w_div_diff  = w_div_shift - {1'b0, opnd_q};
  assign w_div_next  = w_div_diff[W]
                     ? {w_div_shift[W-1:0], prod_q[W-2:0], 1'b0}
                     : {w_div_diff[W-1:0],  prod_q[W-2:0], 1'b1};

  // --------------------------------------------------------------------------
  // Final result formed from the last step's value
  // --------------------------------------------------------------------------
  logic [2*W-1:0] w_mul_signed;
  logic [W-1:0]   w_quo, w_rem;
  logic [W-1:0]   w_final;

  assign w_mul_signed = neg_q ? (-w_mul_next) : w_mul_next;
  assign w_quo        = w_div_next[W-1:0];
  assign w_rem        = w_div_next[2*W-1:W];

  always_comb begin
    w_final = '0;
    case (op_q)
      c_op_mul:                          w_final = w_mul_signed[W-1:0];
      c_op_mulh, c_op_mulhsu, c_op_mulhu: w_final = w_mul_signed[2*W-1:W];
      c_op_div, c_op_divu:               w_final = neg_q  ? (-w_quo) : w_quo;
      c_op_rem, c_op_remu:               w_final = rneg_q ? (-w_rem) : w_rem;
      default:                           w_final = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    case (state_q)
      c_st_idle: begin
        // A load is handled below, and is common to IDLE and DONE.
      end
      c_st_calc: begin
        prod_d = op_q[2] ? w_div_next : w_mul_next;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d  = c_st_done;
          result_d = w_final;
        end
      end
      c_st_done: begin
        if (out_ready) begin
          state_d = c_st_idle;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase

    // An accept is only possible in IDLE, or in DONE while the result is
    // being retired. In the second case, this overrides the return to IDLE,
    // so there is no bubble.
    if (w_accept) begin
      op_d   = w_op;
      neg_d  = w_sa ^ w_sb;
      rneg_d = w_sa;
      if (w_special) begin
        state_d  = c_st_done;
        result_d = w_special_res;
      end else begin
        state_d = c_st_calc;
        cnt_d   = CNT_W'(DATA_WIDTH - 1);
        prod_d  = {{W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
        opnd_d  = w_is_div ? w_b_mag : w_a_mag;
      end
    end

    // Flush discards everything in progress. This includes a result about to
    // be written, and an operation accepted in this same cycle.
    if (flush) begin
      state_d  = c_st_idle;
      result_d = result_q;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= c_st_idle;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

endmodule
`default_nettype wire
